// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction-memory read bus between the fetch stage
// and the instruction memory. The read is combinational: the memory returns
// the word at imem_addr in the same cycle.
//   imem_addr  word address, driven by fetch (master)
//   imem_data  instruction word, driven by memory (slave)
interface instruction_fetch_if #(
  parameter int unsigned B      = 32,
  parameter int unsigned ADDR_W = 7
);
  logic [ADDR_W-1:0] imem_addr;
  logic [B-1:0]      imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage of the 5-stage MIPS pipeline. Holds the PC,
// addresses instruction memory, and presents PC+4 and the fetched word (or a
// NOP) to the IF/ID register. Handles load-use stalls, branch/jump redirects
// with a one-slot squash, a HALT opcode and debug cycle/fetch counters.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   enable               debug run enable (0 freezes everything)
//   stall                load-use stall from hazard unit
//   branch_taken/target  resolved taken branch and its byte address
//   jump/jump_target     jump and its byte address
//   imem                 instruction memory bus (master side)
//   pc_incrementado_out  PC + 4 to IF/ID
//   instruction_out      fetched word, or 0 when halted/redirecting
//   pc_out               current PC
//   halted               fetch stopped on HALT_WORD
//   cycle_count          enabled, non-halted cycles
//   fetch_count          instructions accepted
module instruction_fetch #(
  parameter int unsigned B         = 32,
  parameter int unsigned ADDR_W    = 7,
  parameter logic [B-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [B-1:0]         branch_target,
  input  logic                 jump,
  input  logic [B-1:0]         jump_target,
  instruction_fetch_if.master  imem,
  output logic [B-1:0]         pc_incrementado_out,
  output logic [B-1:0]         instruction_out,
  output logic [B-1:0]         pc_out,
  output logic                 halted,
  output logic [B-1:0]         cycle_count,
  output logic [B-1:0]         fetch_count
);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  localparam logic [B-1:0] ONE        = B'(1);
  localparam logic [B-1:0] FOUR       = B'(4);
  localparam logic [B-1:0] ALIGN_MASK = {{(B-2){1'b1}}, 2'b00};

  state_t       state;
  logic [B-1:0] pc;
  logic [B-1:0] pc_inc;
  logic [B-1:0] target;
  logic         redirect;
  logic         is_halt;

  always_comb begin
    pc_inc   = pc + FOUR;
    redirect = branch_taken | jump;
    // Branch resolves in an older stage than the jump, so it takes precedence.
    target   = (branch_taken ? branch_target : jump_target) & ALIGN_MASK;
    is_halt  = (imem.imem_data == HALT_WORD);
  end

  assign imem.imem_addr      = pc[ADDR_W+1:2];
  assign pc_incrementado_out = pc_inc;
  assign pc_out              = pc;
  assign halted              = (state == S_HALTED);
  assign instruction_out     = (halted || redirect) ? '0 : imem.imem_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_RUN;
      pc          <= '0;
      cycle_count <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (enable) begin
            cycle_count <= cycle_count + ONE;
            if (redirect) begin
              // Fetched word is squashed: not counted, even if it is HALT.
              pc <= target;
            end else if (stall) begin
              pc <= pc;
            end else if (is_halt) begin
              // HALT is passed downstream once, then fetch stops with PC held.
              state       <= S_HALTED;
              fetch_count <= fetch_count + ONE;
            end else begin
              pc          <= pc_inc;
              fetch_count <= fetch_count + ONE;
            end
          end
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed, table-driven bench for instruction_fetch
// with a combinational instruction memory model.
module tb_instruction_fetch;
  localparam int unsigned B      = 32;
  localparam int unsigned ADDR_W = 7;
  localparam logic [31:0] HALT   = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset, enable, stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc_incrementado_out, instruction_out, pc_out, cycle_count, fetch_count;
  logic        halted;
  logic [31:0] mem [0:127];

  int total = 0;
  int bad   = 0;

  instruction_fetch_if #(.B(B), .ADDR_W(ADDR_W)) imem_bus ();
  assign imem_bus.imem_data = mem[imem_bus.imem_addr];

  instruction_fetch #(.B(B), .ADDR_W(ADDR_W), .HALT_WORD(HALT)) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .stall               (stall),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .jump                (jump),
    .jump_target         (jump_target),
    .imem                (imem_bus.master),
    .pc_incrementado_out (pc_incrementado_out),
    .instruction_out     (instruction_out),
    .pc_out              (pc_out),
    .halted              (halted),
    .cycle_count         (cycle_count),
    .fetch_count         (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, st, br;
    logic [31:0] brt;
    logic        jp;
    logic [31:0] jt;
    logic [31:0] pc, instr, fc, cc;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic hlt, input logic [31:0] fc, input logic [31:0] cc);
    check({tag, " pc"}, pc_out, pc);
    check({tag, " pc+4"}, pc_incrementado_out, pc + 32'd4);
    check({tag, " instr"}, instruction_out, instr);
    check({tag, " halted"}, {31'd0, halted}, {31'd0, hlt});
    check({tag, " fetch_count"}, fetch_count, fc);
    check({tag, " cycle_count"}, cycle_count, cc);
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jump = 0; branch_target = '0; jump_target = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // en st br brt jp jt | pc instr fc cc  (state before the edge this row drives)
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h0,   32'd1,   32'd0, 32'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h4,   32'd2,   32'd1, 32'd1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h8,   32'd3,   32'd2, 32'd2};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'hC,   32'd4,   32'd3, 32'd3};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h10,  32'd5,   32'd4, 32'd4};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   32'h14,  32'd6,   32'd5, 32'd5};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   32'h14,  32'd6,   32'd5, 32'd6};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h14,  32'd6,   32'd5, 32'd7};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h41, 1'b1, 32'h20,  32'h18,  32'd0,   32'd6, 32'd8};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h40,  32'd17,  32'd6, 32'd9};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'h0,   32'h40,  32'd0,   32'd6, 32'd9};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h40,  32'd17,  32'd6, 32'd9};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h40,  32'd17,  32'd6, 32'd9};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h1FE, 32'h44,  32'd0,   32'd7, 32'd10};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h1FC, 32'd128, 32'd7, 32'd11};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   32'h200, 32'd1,   32'd8, 32'd12};

    for (int i = 0; i < 128; i++) mem[i] = 32'(i + 1);
    reset = 1'b1; enable = 1'b0;
    clear_inputs();
    #3;
    check_state("reset", 32'h0, 32'd1, 1'b0, 32'd0, 32'd0);
    #9 reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      enable = vecs[i].en; stall = vecs[i].st;
      branch_taken = vecs[i].br; branch_target = vecs[i].brt;
      jump = vecs[i].jp; jump_target = vecs[i].jt;
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, 1'b0, vecs[i].fc, vecs[i].cc);
    end
    clear_inputs();
    enable = 1'b1;

    // Asynchronous reset mid-run, then HALT at word 3.
    next_cycle();
    mem[3] = HALT;
    reset_pulse();
    check_state("async reset", 32'h0, 32'd1, 1'b0, 32'd0, 32'd0);
    repeat (3) next_cycle();
    check_state("halt fetched", 32'hC, HALT, 1'b0, 32'd3, 32'd3);
    next_cycle();
    check_state("halted", 32'hC, 32'h0, 1'b1, 32'd4, 32'd4);
    jump = 1'b1; jump_target = 32'h0; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    next_cycle();
    check_state("halted ignores redirect", 32'hC, 32'h0, 1'b1, 32'd4, 32'd4);
    clear_inputs();
    next_cycle();
    check_state("halted holds", 32'hC, 32'h0, 1'b1, 32'd4, 32'd4);
    reset_pulse();
    check_state("reset clears halt", 32'h0, 32'd1, 1'b0, 32'd0, 32'd0);

    // HALT squashed by a same-cycle jump.
    repeat (3) next_cycle();
    jump = 1'b1; jump_target = 32'h0;
    #1;
    check_state("halt with jump", 32'hC, 32'h0, 1'b0, 32'd3, 32'd3);
    next_cycle();
    jump = 1'b0;
    #1;
    check_state("after squashed halt", 32'h0, 32'd1, 1'b0, 32'd3, 32'd4);

    // PC+4 wraps at the top of the address space; word address aliases.
    jump = 1'b1; jump_target = 32'hFFFFFFFF;
    next_cycle();
    jump = 1'b0;
    #1;
    check_state("pc top", 32'hFFFFFFFC, 32'd128, 1'b0, 32'd3, 32'd5);
    check("imem_addr alias", {25'd0, imem_bus.imem_addr}, 32'h7F);
    next_cycle();
    check_state("pc wrap", 32'h0, 32'd1, 1'b0, 32'd4, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
